// File: rtl/adder_pkg.sv
// Shared widths, pipeline depth derivation and per-stage tag payload for the
// pipelined add/subtract unit.
package adder_pkg;

    localparam int DATA_LEN_DEF  = 32;
    localparam int CHUNK_LEN_DEF = 8;
    localparam int STAGES_DEF    = DATA_LEN_DEF / CHUNK_LEN_DEF;

    localparam logic [DATA_LEN_DEF-1:0] SMAX_DEF = {1'b0, {(DATA_LEN_DEF-1){1'b1}}};
    localparam logic [DATA_LEN_DEF-1:0] SMIN_DEF = {1'b1, {(DATA_LEN_DEF-1){1'b0}}};

    // Control that travels with each op; the partial sum rides alongside in its own array.
    typedef struct packed {
        logic valid;
        logic sub;
        logic sat;
        logic carry;
        logic zero_acc;
    } stage_tag_t;

    function automatic int stages_of(input int data_len, input int chunk_len);
        return data_len / chunk_len;
    endfunction

endpackage

// File: rtl/adder_cla_chunk.sv
// Combinational carry-lookahead slice: expanded generate/propagate carries,
// sum, carry-out and the carry into the slice MSB (for signed overflow).
module adder_cla_chunk
#(
    parameter int WIDTH = 8
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;

    // Each carry is the flat OR of g[j] & p[j+1..i] terms, not a ripple chain.
    function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] pp,
                                                 input logic [WIDTH-1:0] gg,
                                                 input logic             c0);
        logic [WIDTH:0] cc;
        logic           run;
        cc    = '0;
        cc[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                cc[i+1] = cc[i+1] | (gg[j] & run);
                run     = run & pp[j];
            end
            cc[i+1] = cc[i+1] | (c0 & run);
        end
        return cc;
    endfunction

    assign p     = a ^ b;
    assign g     = a & b;
    assign c     = lookahead(p, g, cin);
    assign sum   = p ^ c[WIDTH-1:0];
    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract, one CLA chunk per stage with registered carries and a
// global stall. Optional saturation on signed overflow with ADDER_PIPE_SAT_EN.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int DATA_LEN  = DATA_LEN_DEF,
    parameter int CHUNK_LEN = CHUNK_LEN_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    input  logic                cin,
    input  logic                sub,
    input  logic                sat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] sum,
    output logic                cout,
    output logic                zero,
    output logic                overflow
);

    localparam int STAGES = stages_of(DATA_LEN, CHUNK_LEN);
    localparam int LAST   = STAGES - 1;

    if ((DATA_LEN % CHUNK_LEN) != 0) begin : g_len_check
        $error("adder_pipe: DATA_LEN must be a multiple of CHUNK_LEN");
    end

    logic [DATA_LEN-1:0]  a_q   [STAGES];
    logic [DATA_LEN-1:0]  b_q   [STAGES];
    logic [DATA_LEN-1:0]  s_q   [STAGES];
    stage_tag_t           tag_q [STAGES];
    logic                 ovf_q;

    logic [DATA_LEN-1:0]  a_src   [STAGES];
    logic [DATA_LEN-1:0]  b_src   [STAGES];
    logic [DATA_LEN-1:0]  s_src   [STAGES];
    logic [DATA_LEN-1:0]  s_nxt   [STAGES];
    stage_tag_t           tag_src [STAGES];
    logic [CHUNK_LEN-1:0] csum    [STAGES];
    logic [STAGES-1:0]    ccout;
    logic [STAGES-1:0]    cmsb;
    logic [STAGES-1:0]    zero_nxt;

    logic                 stall;
    logic                 ovf_fin;
    logic                 zero_fin;
    logic [DATA_LEN-1:0]  sum_fin;
    logic                 unused_sink;

    assign stall    = tag_q[LAST].valid && !out_ready;
    assign in_ready = !stall;

    // Stage 0 takes the prepared operands; later stages take the previous stage's registers.
    always_comb begin
        a_src[0]   = a;
        b_src[0]   = sub ? ~b : b;
        s_src[0]   = '0;
        tag_src[0] = '{valid: in_valid && !stall, sub: sub, sat: sat,
                       carry: cin ^ sub, zero_acc: 1'b1};
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
            tag_src[k] = tag_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_cla_chunk #(.WIDTH(CHUNK_LEN)) u_cla (
            .a     (a_src[k][k*CHUNK_LEN +: CHUNK_LEN]),
            .b     (b_src[k][k*CHUNK_LEN +: CHUNK_LEN]),
            .cin   (tag_src[k].carry),
            .sum   (csum[k]),
            .cout  (ccout[k]),
            .c_msb (cmsb[k])
        );
    end

    always_comb begin
        zero_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]                           = s_src[k];
            s_nxt[k][k*CHUNK_LEN +: CHUNK_LEN] = csum[k];
            zero_nxt[k] = tag_src[k].zero_acc && (csum[k] == '0);
        end
    end

    always_comb begin
        ovf_fin  = cmsb[LAST] ^ ccout[LAST];
        sum_fin  = s_nxt[LAST];
        zero_fin = zero_nxt[LAST];
`ifdef ADDER_PIPE_SAT_EN
        // A clamped result is never zero, so zero is cleared with it.
        if (tag_src[LAST].sat && ovf_fin) begin
            sum_fin  = a_src[LAST][DATA_LEN-1] ? {1'b1, {(DATA_LEN-1){1'b0}}}
                                               : {1'b0, {(DATA_LEN-1){1'b1}}};
            zero_fin = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_src[k];
                b_q[k]   <= b_src[k];
                s_q[k]   <= s_nxt[k];
                tag_q[k] <= '{valid: tag_src[k].valid, sub: tag_src[k].sub,
                              sat: tag_src[k].sat, carry: ccout[k],
                              zero_acc: zero_nxt[k]};
            end
            s_q[LAST]          <= sum_fin;
            tag_q[LAST].zero_acc <= zero_fin;
            ovf_q              <= ovf_fin;
        end
    end

    assign out_valid = tag_q[LAST].valid;
    assign sum       = s_q[LAST];
    assign cout      = tag_q[LAST].carry;
    assign zero      = tag_q[LAST].zero_acc;
    assign overflow  = ovf_q;

    // Last-stage operand copies, tags and lower-stage MSB carries have no consumer.
    assign unused_sink = ^{a_q[LAST], b_q[LAST], tag_q[LAST].sub, tag_q[LAST].sat, cmsb, sat};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (32-bit, 8-bit chunks): directed spec cases,
// randomized traffic with stalls, and mid-flight reset, against an arithmetic model.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        zero;
    logic        overflow;

    adder_pipe #(.DATA_LEN(32), .CHUNK_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    localparam longint SMAXL = 64'sd2147483647;
    localparam longint SMINL = -64'sd2147483648;

    // Plain integer arithmetic: unsigned result gives sum/carry, signed result gives overflow.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub, input logic msat);
        exp_t   e;
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'({32'h0, ma});
        ub = longint'({32'h0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ures   = ua - ub - longint'(mcin);
            sres   = sa - sb - longint'(mcin);
            e.cout = (ures >= 0);
        end else begin
            ures   = ua + ub + longint'(mcin);
            sres   = sa + sb + longint'(mcin);
            e.cout = (ures >= 64'sh1_0000_0000);
        end
        e.sum = ures[31:0];
        e.ovf = (sres > SMAXL) || (sres < SMINL);
`ifdef ADDER_PIPE_SAT_EN
        if (msat && e.ovf) e.sum = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (msat && 1'b0) e.sum = '0;
`endif
        e.zero = (e.sum == 32'h0);
        return e;
    endfunction

    logic        prev_stall = 1'b0;
    logic [31:0] prev_sum;
    logic [2:0]  prev_flags;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_sum", sum, prev_sum);
                check("hold_flags", {cout, zero, overflow}, prev_flags);
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, sat));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
                    check("zero", zero, e.zero);
                    check("overflow", overflow, e.ovf);
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                check("in_ready_stall", in_ready, 0);
                prev_sum   = sum;
                prev_flags = {cout, zero, overflow};
            end
        end
    end

    // Offers one op; returns 1 time unit after the accepting edge with in_valid still high.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                         input logic tsub, input logic tsat);
        int waited;
        a = ta; b = tb; cin = tcin; sub = tsub; sat = tsat;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Called right after issue(): counts edges from accept to out_valid and checks the sum.
    task automatic measure(input logic [31:0] exp_sum);
        int lat;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 4);
        check("direct_sum", sum, exp_sum);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, zero, overflow}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        measure(32'h0000_0100);
        drain();
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        measure(32'h0000_0000);
        drain();
        issue(32'd5, 32'd5, 1'b0, 1'b1, 1'b0);
        measure(32'h0000_0000);
        drain();
        issue(32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
        measure(32'hFFFF_FFFE);
        drain();
`ifdef ADDER_PIPE_SAT_EN
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        measure(32'h7FFF_FFFF);
        drain();
        issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        measure(32'h8000_0000);
        drain();
`else
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        measure(32'h8000_0000);
        drain();
        issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        measure(32'h7FFF_FFFF);
        drain();
`endif

        // Eight back-to-back ops with a three-cycle consumer stall.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Longer random run: input gaps, random backpressure, carry-heavy operands.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] ra, rb;
                    ra = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
                    rb = (i % 5 == 0) ? 32'h0 : $urandom;
                    issue(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three ops in flight: none may emerge afterwards.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_drop_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_valid", out_valid, 0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        measure(32'h2345_6789);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
